// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 fetch front end: FSM encoding, reset vector
// default and the instruction alignment mask.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [1:0]  ALIGN_MASK       = 2'b11;

endpackage

// File: rtl/pc_redirect_sel.sv
// Redirect target selection: a jump outranks a taken branch, and the chosen
// target is flagged when it is not word aligned.
module pc_redirect_sel
  import riscv_pkg::*;
(
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        redirect,
  output logic [31:0] target,
  output logic        misaligned
);

  always_comb begin
    redirect   = jump_valid | branch_taken;
    target     = jump_valid ? jump_target : branch_target;
    misaligned = redirect && ((target[1:0] & ALIGN_MASK) != 2'b00);
  end

endmodule

// File: rtl/pc_reg_ctrl.sv
// Architectural PC register and fetch control: boot/run/halt sequencing,
// redirect handling with misaligned-target trap, and an accepted-fetch counter.
module pc_reg_ctrl
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_next_in,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump_valid,
  input  logic [31:0]      jump_target,
  input  logic             stall,
  input  logic             halt_req,
  output logic [31:0]      pc,
  output logic             fetch_valid,
  output logic             redirect_flush,
  output logic             trap,
  output logic [31:0]      trap_addr,
  output logic [CNT_W-1:0] fetch_count
);

  pc_state_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             trap_q, trap_d;
  logic [31:0]      trap_addr_q, trap_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        redirect;
  logic [31:0] target;
  logic        misaligned;

  pc_redirect_sel u_sel (
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .redirect      (redirect),
    .target        (target),
    .misaligned    (misaligned)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_d     = 1'b0;
    trap_d      = trap_q;
    trap_addr_d = trap_addr_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        // Any non-stalled RUN cycle consumes the fetch at pc, whatever follows.
        if (!stall) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (halt_req) begin
            state_d = ST_HALT;
          end else if (redirect) begin
            if (misaligned) begin
              state_d     = ST_HALT;
              trap_d      = 1'b1;
              trap_addr_d = target;
            end else begin
              pc_d    = target;
              flush_d = 1'b1;
            end
          end else begin
            pc_d = pc_next_in;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VECTOR;
      flush_q     <= 1'b0;
      trap_q      <= 1'b0;
      trap_addr_q <= 32'h0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_q     <= flush_d;
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pc             = pc_q;
  assign fetch_valid    = (state_q == ST_RUN);
  assign redirect_flush = flush_q;
  assign trap           = trap_q;
  assign trap_addr      = trap_addr_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_pc_reg_ctrl.sv
// Directed bench for pc_reg_ctrl with a 4-bit fetch counter so counter wrap
// is reachable; pc_next_in mimics the upstream pc+4 adder.
module tb_pc_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_next_in;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        stall;
  logic        halt_req;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        redirect_flush;
  logic        trap;
  logic [31:0] trap_addr;
  logic [3:0]  fetch_count;

  int checks = 0;
  int errors = 0;

  pc_reg_ctrl #(.RESET_VECTOR(32'h0000_0000), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_next_in     (pc_next_in),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump_valid     (jump_valid),
    .jump_target    (jump_target),
    .stall          (stall),
    .halt_req       (halt_req),
    .pc             (pc),
    .fetch_valid    (fetch_valid),
    .redirect_flush (redirect_flush),
    .trap           (trap),
    .trap_addr      (trap_addr),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  assign pc_next_in = pc + 32'd4;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] exp_pc, input logic exp_fv,
                           input logic exp_fl, input logic [3:0] exp_cnt);
    chk({tag, "_pc"},    pc,                   exp_pc);
    chk({tag, "_fv"},    {31'd0, fetch_valid},    {31'd0, exp_fv});
    chk({tag, "_flush"}, {31'd0, redirect_flush}, {31'd0, exp_fl});
    chk({tag, "_cnt"},   {28'd0, fetch_count},    {28'd0, exp_cnt});
  endtask

  initial begin
    rst = 1'b1; branch_taken = 1'b0; branch_target = '0; jump_valid = 1'b0;
    jump_target = '0; stall = 1'b0; halt_req = 1'b0;

    // Reset for two edges, then BOOT one cycle and sequential fetch
    step(); step();
    chk_state("reset", 32'h0, 1'b0, 1'b0, 4'd0);
    chk("reset_trap", {31'd0, trap}, 32'd0);
    chk("reset_taddr", trap_addr, 32'd0);
    rst = 1'b0;
    step(); chk_state("run0", 32'h0, 1'b1, 1'b0, 4'd0);
    step(); chk_state("seq4", 32'h4, 1'b1, 1'b0, 4'd1);
    step(); chk_state("seq8", 32'h8, 1'b1, 1'b0, 4'd2);
    step(); chk_state("seqC", 32'hC, 1'b1, 1'b0, 4'd3);
    step(); chk_state("seq10", 32'h10, 1'b1, 1'b0, 4'd4);

    // Jump beats branch
    jump_valid = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h200;
    step(); chk_state("jmp_prio", 32'h100, 1'b1, 1'b1, 4'd5);
    jump_valid = 1'b0; branch_taken = 1'b0;
    step(); chk_state("after_jmp", 32'h104, 1'b1, 1'b0, 4'd6);

    // Move to 0x20, then stall with a branch held
    jump_valid = 1'b1; jump_target = 32'h20;
    step(); chk_state("jmp20", 32'h20, 1'b1, 1'b1, 4'd7);
    jump_valid = 1'b0;
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    step(); chk_state("stall1", 32'h20, 1'b1, 1'b0, 4'd7);
    step(); chk_state("stall2", 32'h20, 1'b1, 1'b0, 4'd7);
    step(); chk_state("stall3", 32'h20, 1'b1, 1'b0, 4'd7);
    stall = 1'b0;
    step(); chk_state("br80", 32'h80, 1'b1, 1'b1, 4'd8);
    branch_taken = 1'b0;

    // PC wrap through the upstream adder
    jump_valid = 1'b1; jump_target = 32'hFFFF_FFFC;
    step(); chk_state("jmp_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 4'd9);
    jump_valid = 1'b0;
    step(); chk_state("pc_wrap", 32'h0, 1'b1, 1'b0, 4'd10);
    chk("pc_wrap_trap", {31'd0, trap}, 32'd0);

    // Fetch counter wraps at 16 accepted fetches
    step(); step(); step(); step(); step();
    chk_state("cnt15", 32'h14, 1'b1, 1'b0, 4'd15);
    step(); chk_state("cnt_wrap", 32'h18, 1'b1, 1'b0, 4'd0);
    step(); chk_state("cnt17", 32'h1C, 1'b1, 1'b0, 4'd1);

    // Halt at 0x40; inputs ignored afterwards
    jump_valid = 1'b1; jump_target = 32'h40;
    step(); chk_state("jmp40", 32'h40, 1'b1, 1'b1, 4'd2);
    jump_valid = 1'b0; halt_req = 1'b1;
    step(); chk_state("halt", 32'h40, 1'b0, 1'b0, 4'd3);
    halt_req = 1'b0; jump_valid = 1'b1; jump_target = 32'h80;
    step(); chk_state("halt_hold", 32'h40, 1'b0, 1'b0, 4'd3);
    jump_valid = 1'b0;

    // Reset out of HALT
    rst = 1'b1;
    step(); chk_state("rst_halt", 32'h0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    step(); chk_state("run_again", 32'h0, 1'b1, 1'b0, 4'd0);
    step(); chk_state("seq4b", 32'h4, 1'b1, 1'b0, 4'd1);

    // Misaligned branch target traps; later jumps ignored
    branch_taken = 1'b1; branch_target = 32'h102;
    step(); chk_state("trap", 32'h4, 1'b0, 1'b0, 4'd2);
    chk("trap_flag", {31'd0, trap}, 32'd1);
    chk("trap_addr", trap_addr, 32'h102);
    branch_taken = 1'b0; jump_valid = 1'b1; jump_target = 32'h200;
    step(); chk_state("trap_hold", 32'h4, 1'b0, 1'b0, 4'd2);
    chk("trap_hold_flag", {31'd0, trap}, 32'd1);
    chk("trap_hold_addr", trap_addr, 32'h102);
    jump_valid = 1'b0;

    // Reset clears trap; then reset in the middle of a stall
    rst = 1'b1;
    step(); chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_taddr", trap_addr, 32'd0);
    rst = 1'b0;
    step(); step(); chk_state("pre_stall", 32'h4, 1'b1, 1'b0, 4'd1);
    stall = 1'b1;
    step(); chk_state("mid_stall", 32'h4, 1'b1, 1'b0, 4'd1);
    rst = 1'b1;
    step(); chk_state("rst_stall", 32'h0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0; stall = 1'b0;
    step(); chk_state("boot_done", 32'h0, 1'b1, 1'b0, 4'd0);
    step(); chk_state("seq4c", 32'h4, 1'b1, 1'b0, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
